// File: rtl/wb_scoreboard.sv
// Long-latency writeback scoreboard: per-register pending-write counters.
// Ports: clk/rst_n, issue_*, exu_wb_*, rs1/rs2/rd query, flush, outstanding, sb_err.
module wb_scoreboard #(
  parameter int CNT_W = 2,
  parameter int TOT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd_addr,
  output logic             issue_ready,
  input  logic             exu_wb_rd_wr_en,
  input  logic [4:0]       exu_wb_rd_addr,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  input  logic [4:0]       rd_addr,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rd_busy,
  input  logic             flush,
  output logic [TOT_W-1:0] outstanding,
  output logic             sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TOT_W-1:0] TOT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [TOT_W-1:0] tot_q, tot_d;
  logic             err_q, err_d;

  logic wb_hit, wb_dec, wb_bad;
  logic iss_full, tot_full, iss_acc;

  function automatic logic busy_f(
    input logic [CNT_W-1:0] c,
    input logic             byp
  );
    return (c - CNT_W'(byp)) != '0;
  endfunction

  always_comb begin
    wb_hit = exu_wb_rd_wr_en && (exu_wb_rd_addr != 5'd0);
    wb_dec = wb_hit && (cnt_q[exu_wb_rd_addr] != '0);
    wb_bad = wb_hit && (cnt_q[exu_wb_rd_addr] == '0);
  end

  // A retiring writeback frees a slot in the same cycle
  always_comb begin
    iss_full = (cnt_q[issue_rd_addr] == CNT_MAX)
             && !(wb_dec && (exu_wb_rd_addr == issue_rd_addr));
    tot_full = (tot_q == TOT_MAX) && !wb_dec;
    issue_ready = !(iss_full || tot_full);
    iss_acc = issue_valid && issue_ready
            && (issue_rd_addr != 5'd0);
  end

  // Same-cycle writeback bypasses the hazard
  assign rs1_busy = busy_f(cnt_q[rs1_addr],
    wb_dec && (exu_wb_rd_addr == rs1_addr));
  assign rs2_busy = busy_f(cnt_q[rs2_addr],
    wb_dec && (exu_wb_rd_addr == rs2_addr));
  assign rd_busy  = busy_f(cnt_q[rd_addr],
    wb_dec && (exu_wb_rd_addr == rd_addr));

  assign outstanding = tot_q;
  assign sb_err      = err_q;

  always_comb begin
    cnt_d[0] = '0;
    for (int i = 1; i < 32; i++) begin
      logic inc, dec;
      inc = iss_acc && (issue_rd_addr == 5'(i));
      dec = wb_dec && (exu_wb_rd_addr == 5'(i));
      cnt_d[i] = cnt_q[i];
      if (flush)
        cnt_d[i] = '0;
      else if (inc && !dec)
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (dec && !inc)
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end
  end

  always_comb begin
    tot_d = tot_q;
    if (flush)
      tot_d = '0;
    else if (iss_acc && !wb_dec)
      tot_d = tot_q + TOT_W'(1);
    else if (wb_dec && !iss_acc)
      tot_d = tot_q - TOT_W'(1);
    err_d = err_q | wb_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        cnt_q[i] <= '0;
      tot_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++)
        cnt_q[i] <= cnt_d[i];
      tot_q <= tot_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard.
// Directed scenarios plus randomized traffic against a counter-array model.
module tb_wb_scoreboard;

  localparam int CMAX = 3;
  localparam int TMAX = 63;

  logic       clk;
  logic       rst_n;
  logic       issue_valid;
  logic [4:0] issue_rd_addr;
  logic       issue_ready;
  logic       exu_wb_rd_wr_en;
  logic [4:0] exu_wb_rd_addr;
  logic [4:0] rs1_addr, rs2_addr, rd_addr;
  logic       rs1_busy, rs2_busy, rd_busy;
  logic       flush;
  logic [5:0] outstanding;
  logic       sb_err;

  int vecs;
  int errs;

  int mcnt [32];
  bit merr;

  wb_scoreboard #(.CNT_W(2), .TOT_W(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .issue_valid(issue_valid),
    .issue_rd_addr(issue_rd_addr),
    .issue_ready(issue_ready),
    .exu_wb_rd_wr_en(exu_wb_rd_wr_en),
    .exu_wb_rd_addr(exu_wb_rd_addr),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .rd_addr(rd_addr),
    .rs1_busy(rs1_busy),
    .rs2_busy(rs2_busy),
    .rd_busy(rd_busy),
    .flush(flush),
    .outstanding(outstanding),
    .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int msum();
    int s = 0;
    for (int i = 0; i < 32; i++) s += mcnt[i];
    return s;
  endfunction

  function automatic bit m_wbv();
    return exu_wb_rd_wr_en && exu_wb_rd_addr != 0
        && mcnt[exu_wb_rd_addr] > 0;
  endfunction

  function automatic bit m_ready();
    bit wbv = m_wbv();
    bit reg_full = mcnt[issue_rd_addr] == CMAX
        && !(wbv && exu_wb_rd_addr == issue_rd_addr);
    bit all_full = msum() == TMAX && !wbv;
    return !(reg_full || all_full);
  endfunction

  function automatic bit m_busy(input logic [4:0] a);
    int byp = (m_wbv() && exu_wb_rd_addr == a) ? 1 : 0;
    return (mcnt[a] - byp) > 0;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    merr = 0;
  endfunction

  function automatic void m_step();
    bit wbv = m_wbv();
    bit acc = issue_valid && m_ready() && issue_rd_addr != 0;
    if (exu_wb_rd_wr_en && exu_wb_rd_addr != 0
        && mcnt[exu_wb_rd_addr] == 0)
      merr = 1;
    if (flush) begin
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
    end else begin
      if (wbv) mcnt[exu_wb_rd_addr]--;
      if (acc) mcnt[issue_rd_addr]++;
    end
  endfunction

  task automatic idle();
    issue_valid = 0;
    issue_rd_addr = 0;
    exu_wb_rd_wr_en = 0;
    exu_wb_rd_addr = 0;
    rs1_addr = 0;
    rs2_addr = 0;
    rd_addr = 0;
    flush = 0;
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    m_reset();
    #1;
    vecs++;
    if (issue_ready !== 1'b1 || outstanding !== 6'd0
        || sb_err !== 1'b0) begin
      errs++;
      $display("FAIL reset: ready=%b out=%0d err=%b want 1/0/0",
               issue_ready, outstanding, sb_err);
    end
    vecs++;
    if ({rs1_busy, rs2_busy, rd_busy} !== 3'b000) begin
      errs++;
      $display("FAIL reset_busy: got %b want 000",
               {rs1_busy, rs2_busy, rd_busy});
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    idle();
    issue_valid = 1;
    issue_rd_addr = 5;
    #1;
    vecs++;
    if (issue_ready !== 1'b1) begin
      errs++;
      $display("FAIL basic_ready: got %b want 1", issue_ready);
    end
    vecs++;
    if (outstanding !== 6'd0) begin
      errs++;
      $display("FAIL basic_no_early: out=%0d want 0", outstanding);
    end
    rs1_addr = 5;
    vecs++;
    if (rs1_busy !== 1'b0) begin
      errs++;
      $display("FAIL basic_same_cyc: busy=%b want 0", rs1_busy);
    end
    tick();
    idle();
    rs1_addr = 5;
    #1;
    vecs++;
    if (rs1_busy !== 1'b1 || outstanding !== 6'd1) begin
      errs++;
      $display("FAIL basic_busy: busy=%b out=%0d want 1/1",
               rs1_busy, outstanding);
    end
    exu_wb_rd_wr_en = 1;
    exu_wb_rd_addr = 5;
    #1;
    vecs++;
    if (rs1_busy !== 1'b0) begin
      errs++;
      $display("FAIL basic_bypass: busy=%b want 0", rs1_busy);
    end
    tick();
    idle();
    #1;
    vecs++;
    if (outstanding !== 6'd0 || sb_err !== 1'b0) begin
      errs++;
      $display("FAIL basic_retire: out=%0d err=%b want 0/0",
               outstanding, sb_err);
    end
  endtask

  task automatic test_saturate();
    idle();
    issue_valid = 1;
    issue_rd_addr = 7;
    tick();
    tick();
    tick();
    #1;
    vecs++;
    if (issue_ready !== 1'b0 || outstanding !== 6'd3) begin
      errs++;
      $display("FAIL sat_full: ready=%b out=%0d want 0/3",
               issue_ready, outstanding);
    end
    issue_rd_addr = 8;
    #1;
    vecs++;
    if (issue_ready !== 1'b1) begin
      errs++;
      $display("FAIL sat_other: ready=%b want 1", issue_ready);
    end
    issue_rd_addr = 7;
    exu_wb_rd_wr_en = 1;
    exu_wb_rd_addr = 7;
    #1;
    vecs++;
    if (issue_ready !== 1'b1) begin
      errs++;
      $display("FAIL sat_wb_ready: ready=%b want 1", issue_ready);
    end
    tick();
    idle();
    rs1_addr = 7;
    #1;
    vecs++;
    if (outstanding !== 6'd3 || rs1_busy !== 1'b1
        || sb_err !== 1'b0) begin
      errs++;
      $display("FAIL sat_hold: out=%0d busy=%b err=%b want 3/1/0",
               outstanding, rs1_busy, sb_err);
    end
    flush = 1;
    tick();
    idle();
  endtask

  task automatic test_x0();
    idle();
    issue_valid = 1;
    exu_wb_rd_wr_en = 1;
    #1;
    vecs++;
    if (rs1_busy !== 1'b0) begin
      errs++;
      $display("FAIL x0_busy: got %b want 0", rs1_busy);
    end
    tick();
    idle();
    #1;
    vecs++;
    if (outstanding !== 6'd0 || sb_err !== 1'b0
        || rs1_busy !== 1'b0) begin
      errs++;
      $display("FAIL x0_state: out=%0d err=%b busy=%b want 0/0/0",
               outstanding, sb_err, rs1_busy);
    end
  endtask

  task automatic test_err();
    idle();
    exu_wb_rd_wr_en = 1;
    exu_wb_rd_addr = 9;
    #1;
    vecs++;
    if (sb_err !== 1'b0) begin
      errs++;
      $display("FAIL err_early: got %b want 0", sb_err);
    end
    tick();
    idle();
    for (int i = 0; i < 10; i++) begin
      #1;
      vecs++;
      if (sb_err !== 1'b1 || outstanding !== 6'd0) begin
        errs++;
        $display("FAIL err_sticky[%0d]: err=%b out=%0d want 1/0",
                 i, sb_err, outstanding);
      end
      tick();
    end
    flush = 1;
    tick();
    idle();
    #1;
    vecs++;
    if (sb_err !== 1'b1) begin
      errs++;
      $display("FAIL err_flush: got %b want 1", sb_err);
    end
    #2;
    rst_n = 0;
    m_reset();
    #1;
    vecs++;
    if (sb_err !== 1'b0) begin
      errs++;
      $display("FAIL err_reset: got %b want 0", sb_err);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_flush();
    idle();
    issue_valid = 1;
    issue_rd_addr = 3;
    tick();
    issue_rd_addr = 4;
    tick();
    issue_rd_addr = 5;
    tick();
    issue_rd_addr = 6;
    flush = 1;
    #1;
    vecs++;
    if (outstanding !== 6'd3) begin
      errs++;
      $display("FAIL flush_pre: out=%0d want 3", outstanding);
    end
    tick();
    idle();
    rd_addr = 6;
    rs1_addr = 3;
    rs2_addr = 5;
    #1;
    vecs++;
    if (outstanding !== 6'd0
        || {rs1_busy, rs2_busy, rd_busy} !== 3'b000) begin
      errs++;
      $display("FAIL flush_clear: out=%0d busy=%b want 0/000",
               outstanding, {rs1_busy, rs2_busy, rd_busy});
    end
  endtask

  task automatic test_async_reset();
    idle();
    issue_valid = 1;
    issue_rd_addr = 12;
    tick();
    rs2_addr = 12;
    #1;
    vecs++;
    if (rs2_busy !== 1'b1) begin
      errs++;
      $display("FAIL arst_pre: busy=%b want 1", rs2_busy);
    end
    #1;
    rst_n = 0;
    m_reset();
    #1;
    vecs++;
    if (rs2_busy !== 1'b0 || issue_ready !== 1'b1
        || outstanding !== 6'd0) begin
      errs++;
      $display("FAIL arst_now: busy=%b ready=%b out=%0d want 0/1/0",
               rs2_busy, issue_ready, outstanding);
    end
    @(negedge clk);
    rst_n = 1;
    idle();
    exu_wb_rd_wr_en = 1;
    exu_wb_rd_addr = 12;
    tick();
    idle();
    #1;
    vecs++;
    if (sb_err !== 1'b1) begin
      errs++;
      $display("FAIL arst_stale_wb: err=%b want 1", sb_err);
    end
    #1;
    rst_n = 0;
    m_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_tot_full();
    idle();
    issue_valid = 1;
    for (int r = 1; r <= 21; r++) begin
      issue_rd_addr = 5'(r);
      tick();
      tick();
      tick();
    end
    issue_rd_addr = 22;
    #1;
    vecs++;
    if (outstanding !== 6'd63 || issue_ready !== 1'b0) begin
      errs++;
      $display("FAIL tot_full: out=%0d ready=%b want 63/0",
               outstanding, issue_ready);
    end
    exu_wb_rd_wr_en = 1;
    exu_wb_rd_addr = 1;
    #1;
    vecs++;
    if (issue_ready !== 1'b1) begin
      errs++;
      $display("FAIL tot_wb_ready: ready=%b want 1", issue_ready);
    end
    tick();
    idle();
    rd_addr = 22;
    rs1_addr = 1;
    #1;
    vecs++;
    if (outstanding !== 6'd63 || rd_busy !== 1'b1
        || rs1_busy !== 1'b1) begin
      errs++;
      $display("FAIL tot_swap: out=%0d rd=%b rs1=%b want 63/1/1",
               outstanding, rd_busy, rs1_busy);
    end
    flush = 1;
    tick();
    idle();
  endtask

  task automatic test_random();
    idle();
    for (int n = 0; n < 600; n++) begin
      issue_valid = ($urandom_range(0, 9) < 6);
      issue_rd_addr = 5'($urandom_range(0, 7));
      exu_wb_rd_wr_en = ($urandom_range(0, 1) == 1);
      exu_wb_rd_addr = 5'($urandom_range(0, 7));
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = ($urandom_range(0, 1) == 1)
               ? exu_wb_rd_addr : 5'($urandom_range(0, 7));
      rd_addr = issue_rd_addr;
      flush = ($urandom_range(0, 39) == 0);
      if (flush) exu_wb_rd_wr_en = 0;
      #1;
      vecs++;
      if (issue_ready !== m_ready()
          || rs1_busy !== m_busy(rs1_addr)
          || rs2_busy !== m_busy(rs2_addr)
          || rd_busy !== m_busy(rd_addr)
          || outstanding !== 6'(msum())
          || sb_err !== merr) begin
        errs++;
        $display("FAIL rand[%0d]: rdy=%b b=%b%b%b out=%0d err=%b want %b %b%b%b %0d %b",
                 n, issue_ready, rs1_busy, rs2_busy, rd_busy,
                 outstanding, sb_err, m_ready(), m_busy(rs1_addr),
                 m_busy(rs2_addr), m_busy(rd_addr), msum(), merr);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_basic();
    test_saturate();
    test_x0();
    test_err();
    test_flush();
    test_async_reset();
    test_tot_full();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/wb_scoreboard.md
WB_SCOREBOARD -- requirements
Module: wb_scoreboard

Interface
REQ-001 SHALL provide parameter CNT_W, default 2, width of each per-register pending-write counter.
REQ-002 SHALL provide parameter TOT_W, default 6, width of the total-outstanding counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port issue_valid  input  1  an instruction with a long-latency destination (mul/div/load) is issued this cycle.
REQ-006 SHALL have port issue_rd_addr  input  5  destination register of the issued instruction.
REQ-007 SHALL have port issue_ready  output  1  scoreboard can accept an issue this cycle.
REQ-008 SHALL have port exu_wb_rd_wr_en  input  1  EXU writeback strobe for a long-latency result.
REQ-009 SHALL have port exu_wb_rd_addr  input  5  EXU writeback destination register.
REQ-010 SHALL have port rs1_addr, rs2_addr, rd_addr  input  5 each  decode-stage query addresses.
REQ-011 SHALL have port rs1_busy, rs2_busy, rd_busy  output  1 each  queried register has a pending write.
REQ-012 SHALL have port flush  input  1  synchronous clear of all pending state.
REQ-013 SHALL have port outstanding  output  TOT_W  total pending long-latency writes.
REQ-014 SHALL have port sb_err  output  1  sticky error: writeback to a register with zero pending count.

Function
REQ-015 SHALL hold one CNT_W-bit pending counter per register x1..x31; x0 SHALL never be tracked and always reads not-busy.
REQ-016 An issue is accepted when issue_valid && issue_ready && issue_rd_addr!=0.
REQ-017 Accepted issue SHALL increment cnt[issue_rd_addr] at the next edge.
REQ-018 exu_wb_rd_wr_en with exu_wb_rd_addr!=0 and cnt>0 SHALL decrement cnt[exu_wb_rd_addr] at the next edge.
REQ-019 Same-cycle accepted issue and writeback to the same register SHALL leave that counter unchanged; to different registers, both updates SHALL apply.
REQ-020 issue_ready SHALL be 0 when cnt[issue_rd_addr] is at max (2^CNT_W-1) and no same-cycle writeback to that register, or when outstanding is at max (2^TOT_W-1) and no same-cycle valid writeback; otherwise 1.
REQ-021 Busy outputs SHALL be combinational: busy = (cnt[addr] - (wb strobe && wb addr==addr && cnt>0)) > 0, i.e. a same-cycle writeback bypasses (clears) the hazard.
REQ-022 A same-cycle issue SHALL NOT set busy for that cycle's query (visible from next cycle).
REQ-023 outstanding SHALL equal the sum of all counters; updated +1/-1/0 per edge consistent with REQ-017..019.
REQ-024 Writeback with exu_wb_rd_addr!=0 and cnt==0 SHALL leave counters unchanged and set sb_err=1 until reset.
REQ-025 Writeback to x0 SHALL be ignored with no error.
REQ-026 flush SHALL clear all counters and outstanding to 0 at the next edge, overriding same-cycle issue/writeback; sb_err unaffected.

Reset
REQ-027 rst_n low SHALL asynchronously clear all counters, outstanding=0, sb_err=0; hence all busy=0, issue_ready=1.
REQ-028 Reset asserted mid-operation SHALL discard all pending state; writebacks arriving after reset to previously pending registers SHALL set sb_err.

Verification
REQ-029 Issue rd=5, next cycle query rs1=5 -> rs1_busy=1, outstanding=1; writeback rd=5 that cycle -> rs1_busy=0 combinationally, outstanding=0 next cycle.
REQ-030 Issue rd=7 three times (CNT_W=2) -> cnt=3, issue_ready=0 for rd=7 and 1 for rd=8; issue rd=7 with same-cycle wb rd=7 -> issue_ready=1, cnt stays 3.
REQ-031 Issue rd=0 and wb rd=0 -> no state change, outstanding=0, sb_err=0, rs1_busy(rs1=0)=0.
REQ-032 Wb rd=9 with cnt[9]=0 -> sb_err=1, persists over 10 cycles, cleared only by rst_n.
REQ-033 Pending rd=3,4,5 then flush with same-cycle issue rd=6 -> all counters 0, outstanding=0, rd_busy(6)=0.
REQ-034 Pending rd=12, assert rst_n low between edges -> rs2_busy(12)=0 immediately, issue_ready=1, outstanding=0.
